// File: rtl/bw_io_ddr_cal_pkg.sv
// Shared types and constants for the DDR impedance-calibration controller.
package bw_io_ddr_cal_pkg;

    localparam int              CAL_CODE_W     = 8;
    localparam logic [7:0]      CAL_DEF_CODE   = 8'h80;
    localparam logic [7:0]      CAL_TRIAL_INIT = 8'h80;
    localparam logic [7:0]      CAL_RAIL_LO    = 8'h00;
    localparam logic [7:0]      CAL_RAIL_HI    = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        PU_SET,
        PU_CMP,
        PD_SET,
        PD_CMP,
        WAIT_UPD
    } cal_state_e;

    // A code pinned at either rail means the search never found the reference.
    function automatic logic is_rail(input logic [CAL_CODE_W-1:0] code);
        return (code == CAL_RAIL_LO) || (code == CAL_RAIL_HI);
    endfunction

endpackage

// File: rtl/bw_io_ddr_cal_sar.sv
// Single-phase successive-approximation step engine: one bit resolved per step.
module bw_io_ddr_cal_sar
    import bw_io_ddr_cal_pkg::*;
#(
    parameter logic [CAL_CODE_W-1:0] DEF_CODE = CAL_DEF_CODE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  cmp,
    input  logic                  step,
    output logic [CAL_CODE_W-1:0] code,
    output logic                  last_bit
);

    logic [2:0]            bit_idx;
    logic [CAL_CODE_W-1:0] code_nxt;

    assign last_bit = (bit_idx == 3'd0);

    // Comparator high means the trial is too strong: drop the bit under test,
    // then tentatively set the next lower one.
    always_comb begin
        code_nxt = code;
        if (cmp)
            code_nxt[bit_idx] = 1'b0;
        if (bit_idx != 3'd0)
            code_nxt[bit_idx - 3'd1] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            code    <= DEF_CODE;
            bit_idx <= 3'd7;
        end else if (start) begin
            code    <= CAL_TRIAL_INIT;
            bit_idx <= 3'd7;
        end else if (step) begin
            code <= code_nxt;
            if (bit_idx != 3'd0)
                bit_idx <= bit_idx - 3'd1;
        end
    end

endmodule

// File: rtl/bw_io_ddr_imp_cal_ctl.sv
// DDR pad impedance calibration: pull-up then pull-down SAR search against a
// replica pad, with the pad-group codes updated only in a DRAM-idle window.
module bw_io_ddr_imp_cal_ctl
    import bw_io_ddr_cal_pkg::*;
#(
    parameter int                    SETTLE_CYC = 4,
    parameter logic [CAL_CODE_W-1:0] DEF_CODE   = CAL_DEF_CODE
) (
    input  logic                  rclk,
    input  logic                  rst,
    input  logic                  cal_start,
    input  logic                  cal_up_cmp,
    input  logic                  cal_dn_cmp,
    input  logic                  cal_upd_ok,
    output logic [CAL_CODE_W-1:0] cbu_cal,
    output logic [CAL_CODE_W-1:0] cbd_cal,
    output logic [CAL_CODE_W-1:0] cbu,
    output logic [CAL_CODE_W-1:0] cbd,
    output logic                  cal_busy,
    output logic                  cal_done,
    output logic                  cal_err
);

    localparam int         NUM_PH    = 2;  // 0 = pull-up, 1 = pull-down
    localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYC - 1);

    cal_state_e state;
    logic [7:0] cnt;

    logic [NUM_PH-1:0]                 sar_start;
    logic [NUM_PH-1:0]                 sar_step;
    logic [NUM_PH-1:0]                 sar_cmp;
    logic [NUM_PH-1:0]                 sar_last;
    logic [NUM_PH-1:0][CAL_CODE_W-1:0] sar_code;
    logic                              err_now;

    assign sar_start[0] = (state == IDLE) && cal_start;
    assign sar_start[1] = (state == PU_CMP) && sar_last[0];
    assign sar_step[0]  = (state == PU_CMP);
    assign sar_step[1]  = (state == PD_CMP);
    assign sar_cmp      = {cal_dn_cmp, cal_up_cmp};

    genvar g;
    generate
        for (g = 0; g < NUM_PH; g++) begin : g_ph
            bw_io_ddr_cal_sar #(.DEF_CODE(DEF_CODE)) u_sar (
                .clk      (rclk),
                .rst      (rst),
                .start    (sar_start[g]),
                .cmp      (sar_cmp[g]),
                .step     (sar_step[g]),
                .code     (sar_code[g]),
                .last_bit (sar_last[g])
            );
        end
    endgenerate

    // Each engine holds its last result, so cbu_cal keeps the pull-up answer
    // while the pull-down phase runs.
    assign cbu_cal = sar_code[0];
    assign cbd_cal = sar_code[1];
    assign err_now = is_rail(sar_code[0]) || is_rail(sar_code[1]);

    always_ff @(posedge rclk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            cbu      <= DEF_CODE;
            cbd      <= DEF_CODE;
            cal_busy <= 1'b0;
            cal_done <= 1'b0;
            cal_err  <= 1'b0;
        end else begin
            cal_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cal_start) begin
                        state    <= PU_SET;
                        cnt      <= SETTLE_LD;
                        cal_busy <= 1'b1;
                        cal_err  <= 1'b0;
                    end
                end
                PU_SET: begin
                    if (cnt == 8'd0) state <= PU_CMP;
                    else             cnt   <= cnt - 8'd1;
                end
                PU_CMP: begin
                    cnt   <= SETTLE_LD;
                    state <= sar_last[0] ? PD_SET : PU_SET;
                end
                PD_SET: begin
                    if (cnt == 8'd0) state <= PD_CMP;
                    else             cnt   <= cnt - 8'd1;
                end
                PD_CMP: begin
                    cnt   <= SETTLE_LD;
                    state <= sar_last[1] ? WAIT_UPD : PD_SET;
                end
                WAIT_UPD: begin
                    cal_err <= err_now;
                    if (cal_upd_ok) begin
                        // Both buses move on the same edge so no pad sees a
                        // mixed old/new pair.
                        if (!err_now) begin
                            cbu <= sar_code[0];
                            cbd <= sar_code[1];
                        end
                        cal_done <= 1'b1;
                        cal_busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bw_io_ddr_imp_cal_ctl.sv
// Randomized self-checking bench for bw_io_ddr_imp_cal_ctl with a replica-pad model.
module tb_bw_io_ddr_imp_cal_ctl;

    localparam int S   = 4;
    localparam int PH  = 16 * (S + 1);
    localparam int LAT = PH + 2;

    logic       rclk = 1'b0;
    logic       rst = 1'b1, cal_start = 1'b0, cal_upd_ok = 1'b0;
    logic       cal_up_cmp = 1'b0, cal_dn_cmp = 1'b0;
    logic [7:0] cbu_cal, cbd_cal, cbu, cbd;
    logic       cal_busy, cal_done, cal_err;

    int errors = 0, checks = 0;
    int cyc = 0, t_acc = -100000, upd_at = 0, extra_start_at = -1;
    int up_thr = 8'h5A, dn_thr = 8'h33;
    bit up_tied = 0, glitch = 0;
    logic [7:0] exp_cbu = 8'h80, exp_cbd = 8'h80;
    int  done_off;
    bit  early_chg, busy_gap;

    always #5 rclk = ~rclk;

    bw_io_ddr_imp_cal_ctl #(.SETTLE_CYC(S), .DEF_CODE(8'h80)) dut (
        .rclk(rclk), .rst(rst), .cal_start(cal_start), .cal_up_cmp(cal_up_cmp),
        .cal_dn_cmp(cal_dn_cmp), .cal_upd_ok(cal_upd_ok), .cbu_cal(cbu_cal),
        .cbd_cal(cbd_cal), .cbu(cbu), .cbd(cbd), .cal_busy(cal_busy),
        .cal_done(cal_done), .cal_err(cal_err)
    );

    // Replica answer: the strongest code that is not stronger than the reference.
    function automatic logic [7:0] ref_code(input int thr, input bit tied);
        ref_code = 8'h00;
        if (!tied)
            for (int c = 0; c < 256; c++)
                if (!(c > thr)) ref_code = 8'(c);
    endfunction

    function automatic bit rail(input logic [7:0] c);
        return (c == 8'h00) || (c == 8'hFF);
    endfunction

    // Advance one cycle; drive the replica comparators from the trial codes,
    // with noise in every cycle that is not a compare cycle when glitch is set.
    task automatic tick();
        int off;
        @(posedge rclk);
        #1;
        cyc++;
        off        = cyc - t_acc;
        cal_upd_ok = (cyc >= upd_at);
        cal_start  = (cyc == extra_start_at);
        if (glitch && off > 0 && off <= PH && (off % (S + 1)) != 0) begin
            cal_up_cmp = 1'($urandom);
            cal_dn_cmp = 1'($urandom);
        end else begin
            cal_up_cmp = up_tied || (int'(cbu_cal) > up_thr);
            cal_dn_cmp = (int'(cbd_cal) > dn_thr);
        end
    endtask

    task automatic start_cal();
        cal_start = 1'b1;
        t_acc     = cyc;
        tick();
    endtask

    // Runs until cal_done is seen or the offset bound expires; the caller
    // checks done_off, so an expired bound shows up as a failed comparison.
    task automatic run_until(input int last_off);
        done_off  = -1;
        early_chg = 0;
        busy_gap  = 0;
        while (done_off < 0 && (cyc - t_acc) < last_off) begin
            tick();
            if (cal_done) done_off = cyc - t_acc;
            else begin
                if (cbu !== exp_cbu || cbd !== exp_cbd) early_chg = 1;
                if (cal_busy !== 1'b1) busy_gap = 1;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst     = 1'b0;
        exp_cbu = 8'h80;
        exp_cbd = 8'h80;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({cbu, cbd, cbu_cal, cbd_cal} !== {4{8'h80}}) begin
            errors++;
            $display("FAIL reset_codes got=%h want=80808080", {cbu, cbd, cbu_cal, cbd_cal});
        end
        checks++;
        if ({cal_busy, cal_done, cal_err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got=%b want=000", {cal_busy, cal_done, cal_err});
        end
    endtask

    task automatic test_nominal();
        up_thr = 8'h5A; dn_thr = 8'h33; upd_at = 0;
        tick();
        start_cal();
        run_until(8 * (S + 1) + 3);
        checks++;
        if (cbu_cal !== 8'h5A) begin
            errors++; $display("FAIL nom_pu_hold got=%h want=5a", cbu_cal);
        end
        run_until(LAT + 20);
        checks++;
        if (done_off != LAT) begin
            errors++; $display("FAIL nom_latency got=%0d want=%0d", done_off, LAT);
        end
        checks++;
        if ({cbu, cbd, cal_err, cal_busy} !== {8'h5A, 8'h33, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL nom_result got=%h %h err=%b busy=%b want=5a 33 0 0", cbu, cbd, cal_err, cal_busy);
        end
        checks++;
        if (early_chg || busy_gap) begin
            errors++; $display("FAIL nom_hold early_chg=%0d busy_gap=%0d want 0 0", early_chg, busy_gap);
        end
        exp_cbu = 8'h5A; exp_cbd = 8'h33;
        tick();
        checks++;
        if (cal_done !== 1'b0) begin
            errors++; $display("FAIL nom_pulse got=%b want=0", cal_done);
        end
    endtask

    task automatic test_deferred();
        do_reset();
        up_thr = 8'h5A; dn_thr = 8'h33;
        upd_at = cyc + 102;
        start_cal();
        run_until(LAT + 40);
        checks++;
        if (done_off != 103) begin
            errors++; $display("FAIL defer_latency got=%0d want=103", done_off);
        end
        checks++;
        if (early_chg || busy_gap) begin
            errors++; $display("FAIL defer_hold early_chg=%0d busy_gap=%0d want 0 0", early_chg, busy_gap);
        end
        checks++;
        if ({cbu, cbd} !== {8'h5A, 8'h33}) begin
            errors++; $display("FAIL defer_result got=%h %h want=5a 33", cbu, cbd);
        end
        exp_cbu = 8'h5A; exp_cbd = 8'h33;
        upd_at = 0;
    endtask

    task automatic test_rail_error();
        do_reset();
        up_tied = 1; dn_thr = 8'h33;
        start_cal();
        run_until(LAT + 20);
        checks++;
        if (done_off != LAT) begin
            errors++; $display("FAIL rail_latency got=%0d want=%0d", done_off, LAT);
        end
        checks++;
        if ({cal_err, cbu, cbd, cbu_cal} !== {1'b1, 8'h80, 8'h80, 8'h00}) begin
            errors++;
            $display("FAIL rail_result err=%b cbu=%h cbd=%h cbu_cal=%h want 1 80 80 00", cal_err, cbu, cbd, cbu_cal);
        end
        up_tied = 0; up_thr = 8'h5A;
        repeat (3) tick();
        checks++;
        if (cal_err !== 1'b1) begin
            errors++; $display("FAIL rail_sticky got=%b want=1", cal_err);
        end
        start_cal();
        checks++;
        if (cal_err !== 1'b0) begin
            errors++; $display("FAIL rail_clear got=%b want=0", cal_err);
        end
        run_until(LAT + 20);
        checks++;
        if ({done_off == LAT, cal_err, cbu, cbd} !== {1'b1, 1'b0, 8'h5A, 8'h33}) begin
            errors++;
            $display("FAIL rail_recover off=%0d err=%b cbu=%h cbd=%h want %0d 0 5a 33", done_off, cal_err, cbu, cbd, LAT);
        end
        exp_cbu = 8'h5A; exp_cbd = 8'h33;
    endtask

    task automatic test_ignored_start();
        up_thr = 8'h21; dn_thr = 8'hC4;
        tick();
        start_cal();
        extra_start_at = t_acc + 30;
        run_until(LAT + 20);
        extra_start_at = -1;
        checks++;
        if (done_off != LAT || cbu !== 8'h21 || cbd !== 8'hC4) begin
            errors++;
            $display("FAIL ignore_start off=%0d cbu=%h cbd=%h want %0d 21 c4", done_off, cbu, cbd, LAT);
        end
        exp_cbu = 8'h21; exp_cbd = 8'hC4;
        repeat (4) tick();
        checks++;
        if (cal_busy !== 1'b0) begin
            errors++; $display("FAIL ignore_no_queue busy=%b want=0", cal_busy);
        end
    endtask

    task automatic test_reset_midrun();
        up_thr = 8'h9C; dn_thr = 8'h47;
        start_cal();
        run_until(50);
        rst = 1'b1;
        tick();
        checks++;
        if ({cbu, cbd, cbu_cal, cbd_cal, cal_busy, cal_done, cal_err} !== {{4{8'h80}}, 3'b000}) begin
            errors++;
            $display("FAIL midrun_reset got=%h %h %h %h %b%b%b want 80 80 80 80 000",
                     cbu, cbd, cbu_cal, cbd_cal, cal_busy, cal_done, cal_err);
        end
        rst = 1'b0;
        exp_cbu = 8'h80; exp_cbd = 8'h80;
        tick();
        start_cal();
        run_until(LAT + 20);
        checks++;
        if (done_off != LAT || cbu !== 8'h9C || cbd !== 8'h47 || cal_err !== 1'b0) begin
            errors++;
            $display("FAIL midrun_recover off=%0d cbu=%h cbd=%h err=%b want %0d 9c 47 0", done_off, cbu, cbd, cal_err, LAT);
        end
        exp_cbu = 8'h9C; exp_cbd = 8'h47;
    endtask

    task automatic test_back_to_back();
        logic [7:0] eu, ed;
        bit ee;
        int d;
        glitch = 1;
        for (int it = 0; it < 10; it++) begin
            case ($urandom_range(0, 5))
                0:       up_thr = 0;
                1:       up_thr = 255;
                default: up_thr = $urandom_range(0, 255);
            endcase
            dn_thr  = ($urandom_range(0, 7) == 0) ? 255 : $urandom_range(0, 255);
            up_tied = ($urandom_range(0, 7) == 0);
            d       = $urandom_range(0, 15);
            upd_at  = cyc + (LAT - 1) + d;
            eu = ref_code(up_thr, up_tied);
            ed = ref_code(dn_thr, 0);
            ee = rail(eu) || rail(ed);
            start_cal();
            run_until(LAT + 40);
            checks++;
            if (done_off != LAT + d || early_chg || busy_gap) begin
                errors++;
                $display("FAIL b2b_timing it=%0d off=%0d early=%0d gap=%0d want %0d 0 0",
                         it, done_off, early_chg, busy_gap, LAT + d);
            end
            if (!ee) begin exp_cbu = eu; exp_cbd = ed; end
            checks++;
            if ({cbu_cal, cbd_cal, cbu, cbd, cal_err} !== {eu, ed, exp_cbu, exp_cbd, ee}) begin
                errors++;
                $display("FAIL b2b_codes it=%0d got cal=%h/%h bus=%h/%h err=%b want cal=%h/%h bus=%h/%h err=%b",
                         it, cbu_cal, cbd_cal, cbu, cbd, cal_err, eu, ed, exp_cbu, exp_cbd, ee);
            end
            repeat ($urandom_range(0, 3)) tick();
        end
        glitch  = 0;
        up_tied = 0;
        upd_at  = 0;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_deferred();
        test_rail_error();
        test_ignored_start();
        test_reset_midrun();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
